adc_spi_capture: RTL
====================

ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

Purpose: sample-acquisition stage directly upstream of moving_average. Drives a 16-bit SPI ADC, delivers each sample as dout with a one-cycle data_refresh strobe.

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range >=1.
REQ-002 Parameter CONV_CYCLES, default 8: clk cycles cs_n is held low before the first SCLK edge, legal range >=1.
REQ-003 Parameter SAMPLE_DIV, default 1000: clk cycles between sample triggers, legal range >= CONV_CYCLES+32*CLK_DIV+2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  high = periodic triggering runs.
REQ-007 adc_miso  in  1  ADC serial data, MSB first.
REQ-008 adc_cs_n  out  1  ADC chip select, active low.
REQ-009 adc_sclk  out  1  SPI clock, idle low, registered.
REQ-010 dout  out  16  last completed sample; feeds moving_average din.
REQ-011 data_refresh  out  1  one-cycle pulse marking a new dout; feeds moving_average data_refresh.
REQ-012 busy  out  1  high whenever the FSM is not IDLE.
REQ-013 overrun  out  1  one-cycle pulse when a trigger falls while busy.

Function
REQ-014 A trigger counter SHALL count 0..SAMPLE_DIV-1 while enable=1, raise trigger on terminal count, then wrap to 0; with enable=0 the counter SHALL be held at 0.
REQ-015 The FSM SHALL have states IDLE, CONV, SHIFT, DONE; IDLE->CONV on trigger, CONV->SHIFT after CONV_CYCLES cycles, SHIFT->DONE after 16 SCLK periods, DONE->IDLE after one cycle.
REQ-016 adc_cs_n SHALL be low in CONV and SHIFT, high in IDLE and DONE.
REQ-017 In SHIFT, adc_sclk SHALL be low for CLK_DIV cycles, then high for CLK_DIV cycles, 16 times; it ends low.
REQ-018 adc_miso SHALL be sampled in the cycle adc_sclk goes 0->1 and shifted into a 16-bit register MSB first.
REQ-019 In DONE, dout SHALL load the shift register and data_refresh SHALL be high for exactly that one cycle.
REQ-020 Latency: data_refresh SHALL assert exactly CONV_CYCLES+32*CLK_DIV+2 cycles after the trigger cycle.
REQ-021 A trigger while busy=1 SHALL be dropped, pulse overrun for one cycle, and leave the frame in progress undisturbed.
REQ-022 enable falling mid-frame SHALL NOT abort the frame; it completes with data_refresh, then no further triggers.
REQ-023 dout SHALL hold its value between DONE states; data_refresh SHALL never be high in two consecutive cycles.

Reset
REQ-024 rst=1 SHALL force, on the next edge: state IDLE, adc_cs_n=1, adc_sclk=0, dout=0, data_refresh=0, busy=0, overrun=0, trigger counter=0, shift register=0.
REQ-025 rst asserted mid-frame SHALL abandon the frame without any data_refresh pulse; the next frame starts only after a full SAMPLE_DIV count.

Configuration
REQ-026 Macro ADC_SIGN_CONV_EN: when defined, dout SHALL be loaded with bit 15 of the captured word inverted (ADC offset-binary converted to two's complement); when undefined, dout SHALL be loaded with the raw captured word. Timing SHALL be identical in both builds.

Verification
REQ-027 CLK_DIV=2, CONV_CYCLES=4, SAMPLE_DIV=100; ADC model returns 0xA5C3 -> dout=0xA5C3; one data_refresh pulse 4+64+2=70 cycles after trigger; cs_n low for exactly 4+64 cycles.
REQ-028 Same setup, model returns 0x0001,0x0002,0x0003 on successive frames -> dout steps 1,2,3; data_refresh pulses exactly 100 cycles apart; overrun never asserts.
REQ-029 SAMPLE_DIV forced to 50 (below legal minimum) -> every second trigger is dropped with a one-cycle overrun pulse, and dout still equals the model word of each completed frame.
REQ-030 rst pulsed high for one cycle at frame bit 8 -> cs_n=1, sclk=0, dout=0 on next edge; no data_refresh pulse for that frame.
REQ-031 enable dropped in CONV of frame returning 0x1234 -> frame completes with dout=0x1234 and one pulse; no further cs_n activity for 500 cycles.
REQ-032 With ADC_SIGN_CONV_EN defined, model 0x8000 -> dout=0x0000 and 0x7FFF -> dout=0xFFFF; without it, dout=0x8000 and 0x7FFF respectively.

Source files
------------

// File: rtl/adc_spi_capture.sv
// SPI ADC sample-acquisition front end: periodic trigger, conversion wait, 16-bit MSB-first capture.
// Optional build macro ADC_SIGN_CONV_EN converts the offset-binary ADC word to two's complement.
module adc_spi_capture #(
  parameter int CLK_DIV     = 4,
  parameter int CONV_CYCLES = 8,
  parameter int SAMPLE_DIV  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] dout,
  output logic        data_refresh,
  output logic        busy,
  output logic        overrun
);

  localparam int TW = $clog2(SAMPLE_DIV + 1);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   dout_q, dout_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          refresh_q, refresh_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          trigger;

  // NOTE: every _d defaults to its _q (or to 0 for pulses) before the case, so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    sclk_d     = sclk_q;
    refresh_d  = 1'b0;
    overrun_d  = 1'b0;

    trigger = enable && (trig_cnt_q == TW'(SAMPLE_DIV - 1));
    if (!enable || trigger) trig_cnt_d = '0;
    else                    trig_cnt_d = trig_cnt_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d    = CONV;
          conv_cnt_d = '0;
        end
      end
      CONV: begin
        if (conv_cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
        end else begin
          conv_cnt_d = conv_cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Capture on the edge that raises sclk; the ADC has held miso for a full low phase.
          if (!sclk_q) begin
            shift_d = {shift_q[14:0], adc_miso};
          end else if (bit_cnt_q == 4'd15) begin
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        refresh_d = 1'b1;
`ifdef ADC_SIGN_CONV_EN
        dout_d = {~shift_q[15], shift_q[14:0]};
`else
        dout_d = shift_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Dropped trigger: the frame in flight is untouched, only the pulse is raised.
    if (trigger && (state_q != IDLE)) overrun_d = 1'b1;

    cs_n_d = !((state_d == CONV) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge _d values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      trig_cnt_q <= '0;
      conv_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      refresh_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      conv_cnt_q <= conv_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      refresh_q  <= refresh_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign dout         = dout_q;
  assign data_refresh = refresh_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
